cmos_shift_reg: RTL and testbench

Parametrised WIDTH-bit by DEPTH-stage shift register with parallel load, rotate and synchronous clear. Its serial output is driven onto a shared net through a switch-level CMOS tri-state stage built from pmos/nmos primitives. It is the sequential successor to the team's single-bit CMOS inverter cell: it keeps the transistor-level output driver and adds clocked storage, an occupancy counter and bus-sharing capability. Typical use is a serializer stage feeding a wired/shared bus in the switch-level test designs.

---
 rtl/cmos_shift_reg.sv | 84 ++++++++
 tb/tb_cmos_shift_reg.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cmos_shift_reg.sv
// rtl/cmos_shift_reg.sv - WIDTH x DEPTH shift register with load/rotate/clear and a switch-level CMOS tri-state serial output
module cmos_shift_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_sclr,
    input  logic                     i_load,
    input  logic                     i_shift,
    input  logic                     i_rot,
    input  logic [WIDTH-1:0]         i_din,
    input  logic [WIDTH*DEPTH-1:0]   i_pdin,
    input  logic                     i_oe,
    output wire  [WIDTH-1:0]         o_dout,
    output logic [WIDTH*DEPTH-1:0]   o_pdout,
    output logic [CW-1:0]            o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] r_stage [DEPTH];
    logic [CW-1:0]    r_cnt;

    // Stage 0 is the newest entry; stage DEPTH-1 feeds the serial driver.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
            r_cnt <= '0;
        end else if (i_sclr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
            r_cnt <= '0;
        end else if (i_load) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= i_pdin[i*WIDTH +: WIDTH];
            end
            r_cnt <= CNT_MAX;
        end else if (i_shift) begin
            r_stage[0] <= i_rot ? r_stage[DEPTH-1] : i_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
            if (!i_rot && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        o_pdout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_pdout[i*WIDTH +: WIDTH] = r_stage[i];
        end
    end

    assign o_count = r_cnt;
    assign o_full  = (r_cnt == CNT_MAX);
    assign o_empty = (r_cnt == '0);

    supply1 w_vdd;
    supply0 w_gnd;

    wire             w_oe_n = ~i_oe;
    wire [WIDTH-1:0] w_nd   = ~r_stage[DEPTH-1];
    wire [WIDTH-1:0] w_pu_mid;
    wire [WIDTH-1:0] w_pd_mid;

    // The enable transistors sit next to the output so a disabled driver
    // always isolates dout, whatever the floating middle nodes hold.
    for (genvar b = 0; b < WIDTH; b++) begin : g_drv
        pmos u_pu_data (w_pu_mid[b], w_vdd,       w_nd[b]);
        pmos u_pu_oe   (o_dout[b],   w_pu_mid[b], w_oe_n);
        nmos u_pd_oe   (o_dout[b],   w_pd_mid[b], i_oe);
        nmos u_pd_data (w_pd_mid[b], w_gnd,       w_nd[b]);
    end

endmodule

// File: tb/tb_cmos_shift_reg.sv
// tb/tb_cmos_shift_reg.sv - scoreboard testbench for cmos_shift_reg
module tb_cmos_shift_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, sclr, load, shift, rot, oe;
    logic [7:0]  din;
    logic [31:0] pdin;
    tri1  [7:0]  w_dout;
    wire  [31:0] pdout;
    wire  [2:0]  count;
    wire         full, empty;

    logic        load_ab, oe_a, oe_b;
    logic [31:0] pdin_a, pdin_b;
    tri0  [7:0]  w_bus;
    wire  [31:0] pdout_a, pdout_b;
    wire  [2:0]  count_a, count_b;
    wire         full_a, full_b, empty_a, empty_b;

    cmos_shift_reg #(.WIDTH(8), .DEPTH(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sclr(sclr), .i_load(load),
        .i_shift(shift), .i_rot(rot), .i_din(din), .i_pdin(pdin), .i_oe(oe),
        .o_dout(w_dout), .o_pdout(pdout), .o_count(count), .o_full(full), .o_empty(empty)
    );

    cmos_shift_reg #(.WIDTH(8), .DEPTH(4)) u_bus_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_sclr(1'b0), .i_load(load_ab),
        .i_shift(1'b0), .i_rot(1'b0), .i_din(8'h00), .i_pdin(pdin_a), .i_oe(oe_a),
        .o_dout(w_bus), .o_pdout(pdout_a), .o_count(count_a), .o_full(full_a), .o_empty(empty_a)
    );

    cmos_shift_reg #(.WIDTH(8), .DEPTH(4)) u_bus_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_sclr(1'b0), .i_load(load_ab),
        .i_shift(1'b0), .i_rot(1'b0), .i_din(8'h00), .i_pdin(pdin_b), .i_oe(oe_b),
        .o_dout(w_bus), .o_pdout(pdout_b), .o_count(count_b), .o_full(full_b), .o_empty(empty_b)
    );

    typedef struct {
        string       name;
        bit          is_bus;
        logic [31:0] pdout;
        logic [2:0]  count;
        logic        full;
        logic        empty;
        logic [7:0]  dout;
        logic [31:0] pa;
        logic [31:0] pb;
        logic [9:0]  stat;
    } exp_t;

    exp_t q[$];
    event ev_push;
    int   checks = 0;
    int   errors = 0;

    task automatic exp_main(string n, logic [31:0] p, logic [2:0] c, logic f, logic e, logic [7:0] d);
        exp_t x;
        x.name = n; x.is_bus = 1'b0; x.pdout = p; x.count = c; x.full = f; x.empty = e; x.dout = d;
        x.pa = '0; x.pb = '0; x.stat = '0;
        q.push_back(x);
        ->ev_push;
    endtask

    task automatic exp_bus(string n, logic [7:0] b);
        exp_t x;
        x.name = n; x.is_bus = 1'b1; x.pdout = '0; x.count = '0; x.full = 1'b0; x.empty = 1'b0;
        x.dout = b; x.pa = 32'hF000_0000; x.pb = 32'h0F00_0000;
        x.stat = {1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 3'd4};
        q.push_back(x);
        ->ev_push;
    endtask

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Monitor: outputs are sampled 1 ns after each expectation is queued.
    initial begin
        exp_t x;
        forever begin
            @(ev_push);
            #1;
            while (q.size() != 0) begin
                x = q.pop_front();
                if (!x.is_bus) begin
                    chk({x.name, ".pdout"}, pdout, x.pdout);
                    chk({x.name, ".count"}, {29'd0, count}, {29'd0, x.count});
                    chk({x.name, ".full"},  {31'd0, full},  {31'd0, x.full});
                    chk({x.name, ".empty"}, {31'd0, empty}, {31'd0, x.empty});
                    chk({x.name, ".dout"},  {24'd0, w_dout}, {24'd0, x.dout});
                end else begin
                    chk({x.name, ".bus"},   {24'd0, w_bus}, {24'd0, x.dout});
                    chk({x.name, ".pdout_a"}, pdout_a, x.pa);
                    chk({x.name, ".pdout_b"}, pdout_b, x.pb);
                    chk({x.name, ".stat"},
                        {22'd0, full_a, empty_a, count_a, full_b, empty_b, count_b},
                        {22'd0, x.stat});
                end
            end
        end
    end

    task automatic step(logic s_sclr, logic s_load, logic s_shift, logic s_rot,
                        logic [7:0] s_din, logic [31:0] s_pdin, logic s_oe);
        @(negedge clk);
        sclr = s_sclr; load = s_load; shift = s_shift; rot = s_rot;
        din = s_din; pdin = s_pdin; oe = s_oe;
        @(posedge clk);
    endtask

    typedef struct {
        logic        sclr, load, shift, rot;
        logic [7:0]  din;
        logic [31:0] pdin;
        logic [31:0] e_pdout;
        logic [2:0]  e_count;
        logic        e_full, e_empty;
        logic [7:0]  e_dout;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst_n = 1'b0; sclr = 1'b0; load = 1'b0; shift = 1'b0; rot = 1'b0;
        din = '0; pdin = '0; oe = 1'b1;
        load_ab = 1'b0; oe_a = 1'b0; oe_b = 1'b0;
        pdin_a = 32'hF000_0000; pdin_b = 32'h0F00_0000;

        #2 exp_main("rst_oe1", 32'h0, 3'd0, 1'b0, 1'b1, 8'h00);
        #2 oe = 1'b0;
        #1 exp_main("rst_oe0", 32'h0, 3'd0, 1'b0, 1'b1, 8'hFF);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) begin
            step(0, 0, 0, 0, 8'h00, 32'h0, 0);
            exp_main("hold", 32'h0, 3'd0, 1'b0, 1'b1, 8'hFF);
        end

        //        sclr load shift rot din    pdin          pdout         cnt  full empty dout
        vecs = '{
            '{0, 0, 1, 0, 8'hA1, 32'h0,         32'h0000_00A1, 3'd1, 0, 0, 8'h00},
            '{0, 0, 1, 0, 8'hA2, 32'h0,         32'h0000_A1A2, 3'd2, 0, 0, 8'h00},
            '{0, 0, 1, 0, 8'hA3, 32'h0,         32'h00A1_A2A3, 3'd3, 0, 0, 8'h00},
            '{0, 0, 1, 0, 8'hA4, 32'h0,         32'hA1A2_A3A4, 3'd4, 1, 0, 8'hA1},
            '{0, 0, 1, 0, 8'hA5, 32'h0,         32'hA2A3_A4A5, 3'd4, 1, 0, 8'hA2},
            '{0, 1, 0, 0, 8'h00, 32'h4433_2211, 32'h4433_2211, 3'd4, 1, 0, 8'h44},
            '{0, 0, 1, 1, 8'hEE, 32'h0,         32'h3322_1144, 3'd4, 1, 0, 8'h33},
            '{0, 0, 1, 1, 8'hEE, 32'h0,         32'h2211_4433, 3'd4, 1, 0, 8'h22},
            '{0, 0, 1, 1, 8'hEE, 32'h0,         32'h1144_3322, 3'd4, 1, 0, 8'h11},
            '{0, 0, 1, 1, 8'hEE, 32'h0,         32'h4433_2211, 3'd4, 1, 0, 8'h44}
        };
        foreach (vecs[i]) begin
            step(vecs[i].sclr, vecs[i].load, vecs[i].shift, vecs[i].rot, vecs[i].din, vecs[i].pdin, 1'b1);
            exp_main($sformatf("vec%0d", i), vecs[i].e_pdout, vecs[i].e_count,
                     vecs[i].e_full, vecs[i].e_empty, vecs[i].e_dout);
        end
        step(0, 0, 0, 0, 8'h00, 32'h0, 1);

        // oe toggles between edges: combinational on dout, no effect on state
        @(negedge clk) oe = 1'b0;
        #1 exp_main("oe_off", 32'h4433_2211, 3'd4, 1'b1, 1'b0, 8'hFF);
        #2 oe = 1'b1;
        #1 exp_main("oe_on", 32'h4433_2211, 3'd4, 1'b1, 1'b0, 8'h44);

        step(0, 1, 1, 0, 8'h55, 32'hDEAD_BEEF, 1);
        exp_main("load_shift", 32'hDEAD_BEEF, 3'd4, 1'b1, 1'b0, 8'hDE);
        step(1, 1, 1, 1, 8'h55, 32'hDEAD_BEEF, 1);
        exp_main("sclr_all", 32'h0, 3'd0, 1'b0, 1'b1, 8'h00);

        step(0, 0, 1, 0, 8'h81, 32'h0, 1);
        exp_main("pre_rst1", 32'h0000_0081, 3'd1, 1'b0, 1'b0, 8'h00);
        step(0, 0, 1, 0, 8'h82, 32'h0, 1);
        exp_main("pre_rst2", 32'h0000_8182, 3'd2, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        din = 8'hC3; shift = 1'b1;
        #1 rst_n = 1'b0;
        #1 exp_main("async_rst", 32'h0, 3'd0, 1'b0, 1'b1, 8'h00);
        #2 rst_n = 1'b1;
        @(posedge clk);
        exp_main("post_rst", 32'h0000_00C3, 3'd1, 1'b0, 1'b0, 8'h00);
        step(0, 0, 0, 0, 8'h00, 32'h0, 1);
        exp_main("post_hold", 32'h0000_00C3, 3'd1, 1'b0, 1'b0, 8'h00);

        @(negedge clk) load_ab = 1'b1;
        @(negedge clk) load_ab = 1'b0;
        #1 exp_bus("bus_idle", 8'h00);
        @(negedge clk) oe_a = 1'b1;
        #1 exp_bus("bus_a", 8'hF0);
        @(negedge clk) begin oe_a = 1'b0; oe_b = 1'b1; end
        #1 exp_bus("bus_b", 8'h0F);
        @(negedge clk) begin oe_a = 1'b1; oe_b = 1'b0; end
        #1 exp_bus("bus_a2", 8'hF0);
        @(negedge clk) oe_a = 1'b0;
        #1 exp_bus("bus_off", 8'h00);

        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        #3;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
